// File: rtl/mem_burst_reader.sv
// Burst read engine: drives eight consecutive RAM read addresses per cycle
// and streams the captured words as masked 8-lane beats.
module mem_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [ADDR_WIDTH:0]     count_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ADDR_WIDTH-1:0]   read_addr0_o,
    output logic [ADDR_WIDTH-1:0]   read_addr1_o,
    output logic [ADDR_WIDTH-1:0]   read_addr2_o,
    output logic [ADDR_WIDTH-1:0]   read_addr3_o,
    output logic [ADDR_WIDTH-1:0]   read_addr4_o,
    output logic [ADDR_WIDTH-1:0]   read_addr5_o,
    output logic [ADDR_WIDTH-1:0]   read_addr6_o,
    output logic [ADDR_WIDTH-1:0]   read_addr7_o,
    input  logic [DATA_WIDTH-1:0]   mem_data0_i,
    input  logic [DATA_WIDTH-1:0]   mem_data1_i,
    input  logic [DATA_WIDTH-1:0]   mem_data2_i,
    input  logic [DATA_WIDTH-1:0]   mem_data3_i,
    input  logic [DATA_WIDTH-1:0]   mem_data4_i,
    input  logic [DATA_WIDTH-1:0]   mem_data5_i,
    input  logic [DATA_WIDTH-1:0]   mem_data6_i,
    input  logic [DATA_WIDTH-1:0]   mem_data7_i,
    output logic                    beat_valid_o,
    input  logic                    beat_ready_i,
    output logic [8*DATA_WIDTH-1:0] beat_data_o,
    output logic [7:0]              beat_mask_o,
    output logic                    beat_last_o
);

    localparam int AW1 = ADDR_WIDTH + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [AW1-1:0]          remaining;
    logic [DATA_WIDTH-1:0]   mem [8];
    logic                    fetch;
    logic [8*DATA_WIDTH-1:0] fetch_data;
    logic [7:0]              fetch_mask;
    logic                    fetch_last;
    logic [AW1-1:0]          take;

    assign mem[0] = mem_data0_i;
    assign mem[1] = mem_data1_i;
    assign mem[2] = mem_data2_i;
    assign mem[3] = mem_data3_i;
    assign mem[4] = mem_data4_i;
    assign mem[5] = mem_data5_i;
    assign mem[6] = mem_data6_i;
    assign mem[7] = mem_data7_i;

    // Each lane wraps on its own, so base 1020 yields 1020..1023, 0..3.
    assign read_addr0_o = cur_addr;
    assign read_addr1_o = cur_addr + ADDR_WIDTH'(1);
    assign read_addr2_o = cur_addr + ADDR_WIDTH'(2);
    assign read_addr3_o = cur_addr + ADDR_WIDTH'(3);
    assign read_addr4_o = cur_addr + ADDR_WIDTH'(4);
    assign read_addr5_o = cur_addr + ADDR_WIDTH'(5);
    assign read_addr6_o = cur_addr + ADDR_WIDTH'(6);
    assign read_addr7_o = cur_addr + ADDR_WIDTH'(7);

    always_comb begin
        fetch_data = '0;
        fetch_mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (AW1'(k) < remaining) begin
                fetch_mask[k] = 1'b1;
                fetch_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[k];
            end
        end
        fetch_last = (remaining <= AW1'(8));
        take       = fetch_last ? remaining : AW1'(8);
    end

    assign fetch = (state == RUN) && (remaining != '0)
                && (!beat_valid_o || beat_ready_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cur_addr     <= '0;
            remaining    <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            beat_valid_o <= 1'b0;
            beat_data_o  <= '0;
            beat_mask_o  <= '0;
            beat_last_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        if (count_i != '0) begin
                            cur_addr  <= base_addr_i;
                            remaining <= count_i;
                            busy_o    <= 1'b1;
                            state     <= RUN;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fetch) begin
                        beat_data_o  <= fetch_data;
                        beat_mask_o  <= fetch_mask;
                        beat_last_o  <= fetch_last;
                        remaining    <= remaining - take;
                        cur_addr     <= cur_addr + ADDR_WIDTH'(8);
                        beat_valid_o <= 1'b1;
                    end else if (beat_valid_o && beat_ready_i) begin
                        beat_valid_o <= 1'b0;
                    end
                    // The last beat leaves remaining at zero, so no fetch competes here.
                    if (beat_valid_o && beat_ready_i && beat_last_o) begin
                        beat_valid_o <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader; RAM model returns 0xA0000000 | addr
// combinationally on every lane.
module tb_mem_burst_reader;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic [AW-1:0] ra [8];
    logic [DW-1:0] md [8];
    logic          valid;
    logic          ready;
    logic [8*DW-1:0] data;
    logic [7:0]    mask;
    logic          last;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 8; k++) begin : g_ram
        assign md[k] = 32'hA000_0000 | {22'b0, ra[k]};
    end

    mem_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .start_i(start), .base_addr_i(base), .count_i(count),
        .busy_o(busy), .done_o(done),
        .read_addr0_o(ra[0]), .read_addr1_o(ra[1]),
        .read_addr2_o(ra[2]), .read_addr3_o(ra[3]),
        .read_addr4_o(ra[4]), .read_addr5_o(ra[5]),
        .read_addr6_o(ra[6]), .read_addr7_o(ra[7]),
        .mem_data0_i(md[0]), .mem_data1_i(md[1]),
        .mem_data2_i(md[2]), .mem_data3_i(md[3]),
        .mem_data4_i(md[4]), .mem_data5_i(md[5]),
        .mem_data6_i(md[6]), .mem_data7_i(md[7]),
        .beat_valid_o(valid), .beat_ready_i(ready),
        .beat_data_o(data), .beat_mask_o(mask), .beat_last_o(last)
    );

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] beat_of(input logic [AW-1:0] a0,
                                             input logic [7:0] m);
        logic [255:0]  r;
        logic [AW-1:0] a;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            a = a0 + AW'(k);
            if (m[k]) r[k*DW +: DW] = 32'hA000_0000 | {22'b0, a};
        end
        return r;
    endfunction

    // Pulses start for one edge; returns at the negedge after that edge.
    task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] c);
        @(negedge clk);
        start = 1'b1;
        base  = b;
        count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks the beat visible now (waiting a bounded time), then one cycle passes.
    task automatic get_beat(input string tag, input logic [AW-1:0] a0,
                            input logic [7:0] m, input logic l);
        int n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 256'(valid), 256'(1));
        check({tag, "_data"}, data, beat_of(a0, m));
        check({tag, "_mask"}, 256'(mask), 256'(m));
        check({tag, "_last"}, 256'(last), 256'(l));
        check({tag, "_busy"}, 256'(busy), 256'(1));
        check({tag, "_done"}, 256'(done), 256'(0));
        @(negedge clk);
    endtask

    task automatic check_end(input string tag);
        check({tag, "_done"}, 256'(done), 256'(1));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_valid"}, 256'(valid), 256'(0));
        @(negedge clk);
        check({tag, "_done_once"}, 256'(done), 256'(0));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        count = '0;
        ready = 1'b1;
        #12;
        check("rst_valid", 256'(valid), 256'(0));
        check("rst_data", data, 256'(0));
        check("rst_mask", 256'(mask), 256'(0));
        check("rst_last", 256'(last), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_ra3", 256'(ra[3]), 256'(3));
        check("rst_ra7", 256'(ra[7]), 256'(7));
        @(negedge clk);
        rst = 1'b0;

        // Full beats: two full beats, busy for exactly three cycles.
        start_burst(10'd0, 11'd16);
        check("full_busy0", 256'(busy), 256'(1));
        check("full_valid0", 256'(valid), 256'(0));
        @(negedge clk);
        get_beat("full_b1", 10'd0, 8'hFF, 1'b0);
        get_beat("full_b2", 10'd8, 8'hFF, 1'b1);
        check_end("full_end");

        // Partial tail: 11 words from address 5.
        start_burst(10'd5, 11'd11);
        get_beat("part_b1", 10'd5, 8'hFF, 1'b0);
        get_beat("part_b2", 10'd13, 8'h07, 1'b1);
        check_end("part_end");

        // Wrap: lanes cross the top of memory individually.
        start_burst(10'd1020, 11'd8);
        check("wrap_ra0", 256'(ra[0]), 256'(1020));
        check("wrap_ra4", 256'(ra[4]), 256'(0));
        get_beat("wrap_b1", 10'd1020, 8'hFF, 1'b1);
        check_end("wrap_end");

        // Backpressure with an ignored start in the stall window.
        ready = 1'b0;
        start_burst(10'd0, 11'd24);
        @(negedge clk);
        check("bp_valid", 256'(valid), 256'(1));
        check("bp_ra0", 256'(ra[0]), 256'(8));
        for (int i = 0; i < 3; i++) begin
            start = (i == 0);
            base  = 10'd500;
            count = 11'd8;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("bp_hold%0d_data", i), data,
                  beat_of(10'd0, 8'hFF));
            check($sformatf("bp_hold%0d_ra0", i), 256'(ra[0]), 256'(8));
            check($sformatf("bp_hold%0d_valid", i), 256'(valid), 256'(1));
        end
        ready = 1'b1;
        get_beat("bp_b1", 10'd0, 8'hFF, 1'b0);
        get_beat("bp_b2", 10'd8, 8'hFF, 1'b0);
        get_beat("bp_b3", 10'd16, 8'hFF, 1'b1);
        check_end("bp_end");
        check("bp_no_restart", 256'(busy), 256'(0));

        // Zero count: done only.
        start_burst(10'd7, 11'd0);
        check_end("zero");
        check("zero_valid", 256'(valid), 256'(0));

        // Reset while beat 2 of 4 is pending.
        start_burst(10'd0, 11'd32);
        get_beat("rm_b1", 10'd0, 8'hFF, 1'b0);
        check("rm_b2_pending", 256'(valid), 256'(1));
        rst = 1'b1;
        #1;
        check("rm_valid", 256'(valid), 256'(0));
        check("rm_data", data, 256'(0));
        check("rm_mask", 256'(mask), 256'(0));
        check("rm_busy", 256'(busy), 256'(0));
        check("rm_done", 256'(done), 256'(0));
        check("rm_ra0", 256'(ra[0]), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rm_no_done", 256'(done), 256'(0));
        start_burst(10'd100, 11'd8);
        get_beat("rm_new", 10'd100, 8'hFF, 1'b1);
        check_end("rm_new_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_burst_reader.md
# mem_burst_reader

Read-side burst engine for the 8-read-port RAM. It takes a base address and a word count and drives all eight read-address ports of the RAM with consecutive addresses. Each cycle it captures the eight combinational read words into an output register and streams them as 8-lane beats over a valid/ready interface. It sits between the RAM and downstream consumers that need wide, sequential access to memory contents.

## Interface
- DATA_WIDTH, 32, width of one memory word.
- ADDR_WIDTH, 10, RAM address width; memory depth is 2**ADDR_WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- start_i  input  1  begin burst; sampled only in IDLE.
- base_addr_i  input  ADDR_WIDTH  first word address; sampled with start_i.
- count_i  input  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH; sampled with start_i.
- busy_o  output  1  high from accepted start until the last beat handshakes.
- done_o  output  1  one-cycle pulse when the burst completes.
- read_addr0_o..read_addr7_o  output  ADDR_WIDTH each  RAM read addresses for lanes 0..7.
- mem_data0_i..mem_data7_i  input  DATA_WIDTH each  RAM read data for lanes 0..7. The RAM is asynchronous-read: data is valid in the same cycle as its address.
- beat_valid_o  output  1  beat registers hold a valid beat.
- beat_ready_i  input  1  consumer accepts the beat.
- beat_data_o  output  8*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- beat_mask_o  output  8  bit k set means lane k carries a real word.
- beat_last_o  output  1  final beat of the burst.

## Operation
- Registers:
  - cur_addr (ADDR_WIDTH)
  - remaining (ADDR_WIDTH+1)
  - state: IDLE or RUN
  - beat output registers
- read_addrK_o = (cur_addr + K) mod 2**ADDR_WIDTH, continuously for K = 0..7, in every state.
- **IDLE:**
  - start_i=1 and count_i!=0: cur_addr<=base_addr_i, remaining<=count_i, go RUN.
  - start_i=1 and count_i=0: pulse done_o next cycle, stay IDLE, no beats are produced.
  - start_i=0: hold.
- **RUN:**
  - fetch = (remaining!=0) && (!beat_valid_o || beat_ready_i).
  - On fetch:
    - lane K data <= mem_dataK_i if K < remaining, else 0.
    - beat_mask_o <= bit K set iff K < remaining.
    - beat_last_o <= (remaining <= 8).
    - remaining <= remaining - min(8, remaining).
    - cur_addr <= cur_addr + 8 (wraps modulo 2**ADDR_WIDTH).
    - beat_valid_o <= 1.
  - Handshake without fetch (beat_valid_o && beat_ready_i && remaining==0): beat_valid_o <= 0.
  - Handshake on a beat with beat_last_o=1: next state IDLE, done_o pulses for one cycle, beat_valid_o <= 0, busy_o drops.
- start_i is ignored while in RUN.
- While beat_valid_o=1 and beat_ready_i=0, beat_data_o, beat_mask_o, beat_last_o and cur_addr are held stable.
- Address arithmetic is modulo 2**ADDR_WIDTH with no error on wrap; lanes wrap individually (for example, base 1020 gives lanes 1020..1023, 0..3).

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, cur_addr=0, remaining=0.
  - beat_valid_o=0, beat_data_o=0, beat_mask_o=0, beat_last_o=0.
  - done_o=0, busy_o=0.
  - read_addrK_o=K.
- busy_o = (state==RUN), registered.
- Start latency:
  - start_i is sampled at edge t.
  - First fetch happens at edge t+1, so beat_valid_o is high after t+1.
- Throughput is 1 beat per cycle with beat_ready_i held high; N words take ceil(N/8) beats.
- done_o is high in the cycle after the last beat's handshake edge; busy_o is low in the same cycle.
- Reset asserted mid-burst aborts immediately. No done_o is generated; the next start after reset release behaves normally.

## Test plan
- **Full beats:** base=0, count=16, ready=1, mem[i]=i.
  - Beat 1: lanes 0..7, mask 0xFF, last=0.
  - Beat 2: lanes 8..15, mask 0xFF, last=1.
  - done_o pulses once; busy_o is high for 3 cycles.
- **Partial tail:** base=5, count=11.
  - Beat 1: addresses 5..12, mask 0xFF.
  - Beat 2: data 13,14,15 in lanes 0..2, mask 0x07, lanes 3..7 = 0, last=1.
- **Wrap:** ADDR_WIDTH=10, base=1020, count=8.
  - One beat with data from 1020..1023, 0..3, mask 0xFF, last=1.
- **Backpressure:** base=0, count=24, ready low for 3 cycles after the first valid.
  - Beat data and read_addr0_o (=8) stay stable.
  - A start_i pulse during this window is ignored.
  - All 3 beats are delivered in order.
- **Zero count:** start with count=0.
  - done_o pulses the next cycle; beat_valid_o and busy_o never assert.
- **Reset mid-burst:** assert rst while beat 2 of 4 is pending.
  - All outputs go to their reset values at once; no done_o pulse.
  - A new burst (base=100, count=8) after release completes correctly.
